aes_key_whiten_stage: RTL and testbench
=======================================

# aes_key_whiten_stage

Parametrised successor of the pipelined AES round-0 stage. It performs the initial AddRoundKey (input whitening) for one 128-bit block per cycle. It selects the round-0 key from either a 128-bit or 256-bit key bus, carries a sideband tag, and uses a valid/ready handshake with a 2-entry skid buffer, so the stage absorbs back-pressure from round 1 without dropping blocks. It sits between the block input interface and the first full cipher round of the encryption pipeline.

## Interface
- BLOCK_LENGTH, 128, data width; only 128 is legal (elaboration error otherwise)
- KEY_LENGTH, 128, key bus width; 128 or 256 legal
- TAG_WIDTH, 4, sideband tag width (>=1), passed through unchanged
- CNT_WIDTH, 16, width of accepted-block counter
---
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream block present
- in_ready  out  1  stage can accept; in_ready = !skid_valid && !flush
- IN  in  BLOCK_LENGTH  plaintext block
- KEY  in  KEY_LENGTH  cipher key, sampled with IN on accept
- in_tag  in  TAG_WIDTH  sideband tag, sampled with IN
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  OUT/out_tag hold a whitened block
- out_ready  in  1  downstream (round 1) accepts
- OUT  out  BLOCK_LENGTH  IN XOR round-0 key
- out_tag  out  TAG_WIDTH  tag of block on OUT
- blk_count  out  CNT_WIDTH  number of blocks accepted since reset, mod 2^CNT_WIDTH

## Operation
- Round-0 key = KEY[KEY_LENGTH-1 -: 128] (most-significant 128 bits); for KEY_LENGTH=128 this is the whole KEY.
- accept = in_valid && in_ready; pop = out_valid && out_ready.
- Storage: output register (out_valid, OUT, out_tag) and skid register (skid_valid, skid_data, skid_tag). Whitening XOR is computed before storage, so both registers hold whitened data.
- States, derived from the valid bits:
  - EMPTY: out_valid=0.
  - ONE: out_valid=1, skid_valid=0.
  - FULL: both valid.
- Transitions:
  - EMPTY + accept -> ONE; output register loaded.
  - ONE + accept + pop -> ONE; output register reloaded.
  - ONE + accept + !pop -> FULL; new block goes to skid.
  - ONE + pop + !accept -> EMPTY.
  - FULL + pop -> ONE; skid moves to output, skid cleared. No accept is possible in FULL because in_ready=0.
  - FULL + !pop -> FULL; hold.
- Ordering is strictly FIFO. No block is duplicated or dropped except by flush.
- Whenever a register is empty, its data and tag are driven to 0. OUT = 0 and out_tag = 0 whenever out_valid=0.
- flush, when high at a rising edge:
  - out_valid and skid_valid are cleared, and data and tags are zeroed.
  - Flush overrides pop and accept in that cycle.
  - blk_count is not changed.
- blk_count increments by 1 on every accept and wraps from 2^CNT_WIDTH-1 to 0. It does not count flushed or popped blocks separately.

## Timing
- Reset (rst=0, asynchronous): out_valid=0, OUT=0, out_tag=0, skid cleared, blk_count=0. in_ready=1 when flush=0.
- Release of rst is synchronous to clk. The first accept is possible on the first rising edge after release.
- Latency: a block accepted at edge N appears on OUT with out_valid=1 after edge N, when taken from EMPTY, or when taken from ONE with a simultaneous pop.
- Throughput: 1 block/cycle while out_ready=1.
- in_ready is a pure function of registered skid_valid and the flush input. It has no combinational path from out_ready.
- OUT, out_tag and out_valid are registered outputs with no combinational path from inputs.
- Stall: while out_valid=1 and out_ready=0, OUT and out_tag are held stable.
- Reset asserted mid-transfer discards all held blocks immediately. Asserting it with both registers full produces the reset values with no partial output.

## Test plan
- **Reset/idle:** hold rst=0, then release -> out_valid=0, OUT=0, blk_count=0, in_ready=1.
- **FIPS-197 vector, KEY_LENGTH=128:** IN=00112233445566778899aabbccddeeff, KEY=000102030405060708090a0b0c0d0e0f, in_tag=5, out_ready=1 -> next cycle OUT=00102030405060708090a0b0c0d0e0f0, out_tag=5, blk_count=1.
- **KEY_LENGTH=256:** same IN with KEY=000102…1e1f -> OUT=00102030405060708090a0b0c0d0e0f0, showing only the upper 128 bits are used.
- **Back-pressure:** out_ready=0 while presenting 3 back-to-back blocks (tags 1,2,3) -> blocks 1 and 2 accepted, in_ready=0 on block 3, OUT holds tag 1. Then raise out_ready -> tags 1,2,3 emerge in order, none lost, blk_count=3.
- **Flush:** in FULL state, pulse flush with in_valid=1 -> next cycle out_valid=0, OUT=0, in_ready=1, blk_count unchanged. The block presented during flush is not accepted.
- **Counter wrap:** CNT_WIDTH=4, stream 17 blocks -> blk_count reads 15 after the 15th accept, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/aes_key_whiten_stage.sv
// aes_key_whiten_stage
//
// AES round-0 stage that performs the initial AddRoundKey (input whitening)
// on one 128-bit block per cycle. The round-0 key is the most-significant
// 128 bits of the key bus. A sideband tag travels with each block. Blocks
// pass through a 2-deep skid structure (output register + skid register),
// so back-pressure from round 1 is absorbed without losing blocks.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (accept = in_valid && in_ready, pop = out_valid && out_ready).
// A producer holds valid and its payload stable until it sees ready; ready
// may change freely. in_ready depends only on registered state and flush,
// never on out_ready.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   upstream block present
//   in_ready   out  stage can accept (no block in skid, no flush)
//   IN         in   plaintext block
//   KEY        in   cipher key, sampled with IN on accept
//   in_tag     in   sideband tag, sampled with IN
//   flush      in   synchronous flush; drops all held blocks
//   out_valid  out  OUT/out_tag hold a whitened block
//   out_ready  in   downstream accepts
//   OUT        out  IN xor round-0 key (0 when out_valid=0)
//   out_tag    out  tag of block on OUT (0 when out_valid=0)
//   blk_count  out  blocks accepted since reset, wrapping
//   state      out  debug: occupancy (0 = EMPTY, 1 = ONE, 2 = FULL)

module aes_key_whiten_stage #(
  parameter int BLOCK_LENGTH = 128,
  parameter int KEY_LENGTH   = 128,
  parameter int TAG_WIDTH    = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic [KEY_LENGTH-1:0]   KEY,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] OUT,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic [CNT_WIDTH-1:0]    blk_count,
  output logic [1:0]              state
);

  if (BLOCK_LENGTH != 128) begin : g_bad_block_length
    $error("aes_key_whiten_stage: BLOCK_LENGTH must be 128");
  end
  if (KEY_LENGTH != 128 && KEY_LENGTH != 256) begin : g_bad_key_length
    $error("aes_key_whiten_stage: KEY_LENGTH must be 128 or 256");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag_width
    $error("aes_key_whiten_stage: TAG_WIDTH must be at least 1");
  end

  // Encoding equals the number of blocks held, which the debug port exposes.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [BLOCK_LENGTH-1:0] out_data_q, out_data_d;
  logic [TAG_WIDTH-1:0]    out_tag_q, out_tag_d;
  logic [BLOCK_LENGTH-1:0] skid_data_q, skid_data_d;
  logic [TAG_WIDTH-1:0]    skid_tag_q, skid_tag_d;
  logic [CNT_WIDTH-1:0]    cnt_q;

  logic                    skid_valid;
  logic                    accept;
  logic                    pop;
  logic [BLOCK_LENGTH-1:0] whitened;

  // For a 256-bit key the lower half belongs to later rounds and is unused here.
  logic unused_key_bits;
  assign unused_key_bits = ^KEY;

  assign whitened   = IN ^ KEY[KEY_LENGTH-1 -: BLOCK_LENGTH];

  assign out_valid  = (state_q != S_EMPTY);
  assign skid_valid = (state_q == S_FULL);
  assign in_ready   = !skid_valid && !flush;
  assign accept     = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  assign OUT        = out_data_q;
  assign out_tag    = out_tag_q;
  assign blk_count  = cnt_q;
  assign state      = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
      // accept is already gated by flush through in_ready.
      cnt_q       <= cnt_q + CNT_WIDTH'(accept);
    end
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;

    if (flush) begin
      state_d     = S_EMPTY;
      out_data_d  = '0;
      out_tag_d   = '0;
      skid_data_d = '0;
      skid_tag_d  = '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d    = S_ONE;
            out_data_d = whitened;
            out_tag_d  = in_tag;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            out_data_d = whitened;
            out_tag_d  = in_tag;
          end else if (accept) begin
            state_d     = S_FULL;
            skid_data_d = whitened;
            skid_tag_d  = in_tag;
          end else if (pop) begin
            state_d    = S_EMPTY;
            out_data_d = '0;
            out_tag_d  = '0;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a pop can change anything.
          if (pop) begin
            state_d     = S_ONE;
            out_data_d  = skid_data_q;
            out_tag_d   = skid_tag_q;
            skid_data_d = '0;
            skid_tag_d  = '0;
          end
        end
        default: begin
          state_d     = S_EMPTY;
          out_data_d  = '0;
          out_tag_d   = '0;
          skid_data_d = '0;
          skid_tag_d  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_whiten_stage.sv
module tb_aes_key_whiten_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic         in_valid  = 1'b0;
  logic         flush     = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data   = '0;
  logic [255:0] key       = '0;
  logic [3:0]   in_tag    = '0;

  // 256-bit key instance with a 4-bit counter
  logic         in_ready_a, out_valid_a;
  logic [127:0] out_a;
  logic [3:0]   out_tag_a;
  logic [3:0]   blk_a;
  logic [1:0]   state_a;

  // 128-bit key instance with a 16-bit counter, fed the upper key half
  logic         in_ready_b, out_valid_b;
  logic [127:0] out_b;
  logic [3:0]   out_tag_b;
  logic [15:0]  blk_b;
  logic [1:0]   state_b;

  aes_key_whiten_stage #(
    .BLOCK_LENGTH(128), .KEY_LENGTH(256), .TAG_WIDTH(4), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .IN(in_data), .KEY(key), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid_a), .out_ready(out_ready), .OUT(out_a),
    .out_tag(out_tag_a), .blk_count(blk_a), .state(state_a)
  );

  aes_key_whiten_stage #(
    .BLOCK_LENGTH(128), .KEY_LENGTH(128), .TAG_WIDTH(4), .CNT_WIDTH(16)
  ) dut128 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .IN(in_data), .KEY(key[255:128]), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid_b), .out_ready(out_ready), .OUT(out_b),
    .out_tag(out_tag_b), .blk_count(blk_b), .state(state_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of at most two whitened blocks {tag, data}.
  logic [131:0] exp_q[$];
  int unsigned  acc_cnt = 0;

  always @(posedge clk or negedge rst) begin : model
    logic m_acc, m_pop;
    if (!rst) begin
      exp_q.delete();
      acc_cnt <= 0;
    end else begin
      m_acc = in_valid && (exp_q.size() < 2) && !flush;
      m_pop = (exp_q.size() > 0) && out_ready;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_acc) exp_q.push_back({in_tag, in_data ^ key[255:128]});
      end
      if (m_acc) acc_cnt <= acc_cnt + 1;
    end
  end

  // Compare process: every falling edge while out of reset.
  always @(negedge clk) begin : compare
    logic [131:0] head;
    logic         exp_rdy;
    if (rst) begin
      head    = (exp_q.size() > 0) ? exp_q[0] : '0;
      exp_rdy = (exp_q.size() < 2) && !flush;
      chk("out_valid_a", {255'd0, out_valid_a}, {255'd0, exp_q.size() > 0});
      chk("out_a",       {128'd0, out_a},       {128'd0, head[127:0]});
      chk("out_tag_a",   {252'd0, out_tag_a},   {252'd0, head[131:128]});
      chk("in_ready_a",  {255'd0, in_ready_a},  {255'd0, exp_rdy});
      chk("blk_a",       {252'd0, blk_a},       {252'd0, acc_cnt[3:0]});
      chk("state_a",     {254'd0, state_a},     256'(exp_q.size()));
      chk("out_valid_b", {255'd0, out_valid_b}, {255'd0, exp_q.size() > 0});
      chk("out_b",       {128'd0, out_b},       {128'd0, head[127:0]});
      chk("out_tag_b",   {252'd0, out_tag_b},   {252'd0, head[131:128]});
      chk("in_ready_b",  {255'd0, in_ready_b},  {255'd0, exp_rdy});
      chk("blk_b",       {240'd0, blk_b},       {240'd0, acc_cnt[15:0]});
      chk("state_b",     {254'd0, state_b},     256'(exp_q.size()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_block(input logic [3:0] tag);
    in_data = {$urandom, $urandom, $urandom, $urandom};
    key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_tag  = tag;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset / idle
    repeat (3) tick();
    chk("rst_out_valid", {255'd0, out_valid_a}, 256'd0);
    chk("rst_out",       {128'd0, out_a},       256'd0);
    chk("rst_blk",       {252'd0, blk_a},       256'd0);
    chk("rst_in_ready",  {255'd0, in_ready_a},  256'd1);
    rst = 1'b1;
    tick();

    // FIPS-197 vector: both key widths give the same round-0 result
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 128'h00112233445566778899aabbccddeeff;
    key       = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    in_tag    = 4'd5;
    tick();
    chk("fips_out_256", {128'd0, out_a},     {128'd0, 128'h00102030405060708090a0b0c0d0e0f0});
    chk("fips_out_128", {128'd0, out_b},     {128'd0, 128'h00102030405060708090a0b0c0d0e0f0});
    chk("fips_tag",     {252'd0, out_tag_a}, 256'd5);
    chk("fips_blk_128", {240'd0, blk_b},     256'd1);
    in_valid = 1'b0;
    tick();
    chk("fips_drain_valid", {255'd0, out_valid_a}, 256'd0);
    chk("fips_drain_out",   {128'd0, out_b},       256'd0);

    // Back-pressure: three back-to-back blocks, downstream stalled
    rst = 1'b0;
    #1;
    rst = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_block(4'd1);
    tick();
    rand_block(4'd2);
    tick();
    rand_block(4'd3);
    #1;
    chk("bp_in_ready_full", {255'd0, in_ready_a}, 256'd0);
    chk("bp_hold_tag1",     {252'd0, out_tag_a},  256'd1);
    tick();
    chk("bp_stall_tag1",    {252'd0, out_tag_a},  256'd1);
    chk("bp_blk_two",       {252'd0, blk_a},      256'd2);
    out_ready = 1'b1;
    tick();
    chk("bp_order_tag2",    {252'd0, out_tag_a},  256'd2);
    tick();
    chk("bp_order_tag3",    {252'd0, out_tag_a},  256'd3);
    in_valid = 1'b0;
    tick();
    chk("bp_empty",         {255'd0, out_valid_a}, 256'd0);
    chk("bp_blk_three",     {252'd0, blk_a},       256'd3);

    // Flush from FULL with a block presented
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_block(4'd7);
    tick();
    rand_block(4'd8);
    tick();
    rand_block(4'd9);
    flush = 1'b1;
    #1;
    chk("fl_in_ready_low", {255'd0, in_ready_a}, 256'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_out_valid", {255'd0, out_valid_a}, 256'd0);
    chk("fl_out_zero",  {128'd0, out_a},       256'd0);
    chk("fl_in_ready",  {255'd0, in_ready_a},  256'd1);
    chk("fl_blk_kept",  {252'd0, blk_a},       256'd5);

    // Reset asserted while both registers are full
    in_valid = 1'b1;
    rand_block(4'd4);
    tick();
    rand_block(4'd6);
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {255'd0, out_valid_a}, 256'd0);
    chk("mid_rst_out",   {128'd0, out_a},       256'd0);
    chk("mid_rst_tag",   {252'd0, out_tag_a},   256'd0);
    chk("mid_rst_blk",   {252'd0, blk_a},       256'd0);
    chk("mid_rst_state", {254'd0, state_a},     256'd0);
    rst = 1'b1;
    tick();

    // Counter wrap on the 4-bit instance
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      rand_block(4'(i));
      tick();
      if (i == 15) chk("wrap_15", {252'd0, blk_a}, 256'd15);
      if (i == 16) chk("wrap_16", {252'd0, blk_a}, 256'd0);
      if (i == 17) chk("wrap_17", {252'd0, blk_a}, 256'd1);
    end
    in_valid = 1'b0;
    repeat (2) tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rand_block(4'($urandom_range(0, 15)));
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
